mpe_feeder: RTL and testbench
=============================

# mpe_feeder

Upstream feeder for the 9x1 MPE processing-element column. It accepts one weight set and then a run of fmap vectors (one 32-bit value per PE per step) over valid/ready handshakes. It drives the MPE's weight bus and weight_en, and skews each fmap vector so that lane k reaches PE k exactly k cycles after lane 0, raising the per-PE left/right enables in that staggered pattern. It replaces hand-sequenced per-PE enables with a deterministic wavefront.

## Interface
- DATA_WIDTH, 32, width of one weight/fmap word (IEEE-754 single)
- NUMBER_PE, 9, number of PEs driven; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_clk  in  1  clock, all state on rising edge
- i_rest  in  1  reset, asynchronous, active-high
- i_w_valid  in  1  weight set offered
- o_w_ready  out  1  weight set accepted this cycle
- i_w_data  in  NUMBER_PE*DATA_WIDTH  weight set, lane k to PE k
- i_x_valid  in  1  fmap vector offered
- o_x_ready  out  1  fmap vector accepted this cycle
- i_x_data  in  NUMBER_PE*DATA_WIDTH  fmap vector, lane k to PE k
- i_x_last  in  1  qualifies i_x_data as final vector of the run
- o_weight_en  out  1  weight bus valid (level, to MPE weight_en)
- o_weight  out  NUMBER_PE*DATA_WIDTH  registered weight set
- o_fmap  out  NUMBER_PE*DATA_WIDTH  skewed fmap, lane k to i_fmap_f_left_k
- o_left_en  out  NUMBER_PE  per-PE left enable (bit k to i_left_en(k+1))
- o_right_en  out  NUMBER_PE  per-PE right enable, identical to o_left_en
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: o_w_ready=1, o_x_ready=0. A handshake (i_w_valid & o_w_ready) captures i_w_data into o_weight and moves to STREAM.
- STREAM: o_w_ready=0, o_x_ready=1. Each handshake injects {valid=1, i_x_data} into the skew line. A cycle with no handshake injects a bubble {valid=0, data=0}. A handshake with i_x_last=1 moves to DRAIN and loads the drain counter with NUMBER_PE+1.
- DRAIN: both readies 0. Bubbles are injected and the counter decrements each cycle. The edge at which the counter reads 1 moves the FSM to IDLE.
- Skew line: lane k is a k+1-stage register chain of {valid, data}, so lane 0 has 1 stage and lane NUMBER_PE-1 has NUMBER_PE stages. o_fmap lane k and o_left_en[k] are the final stage of lane k.
- Invalid slots present o_fmap lane = 0. Enables are never forced high.
- o_weight_en is high in STREAM and DRAIN and low in IDLE. o_weight holds its value until the next capture.
- A weight set and an fmap vector are never accepted in the same cycle. i_x_valid is ignored in IDLE.
- A run contains at least one vector. i_x_last is sampled only on an fmap handshake.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, all skew stages {0,0}, o_weight=0, o_weight_en=0, o_fmap=0, o_left_en=0, o_right_en=0, o_busy=0. Consequently o_w_ready=1 and o_x_ready=0 immediately.
- Weight handshake at edge f: after f, o_weight and o_weight_en=1 are valid and o_x_ready=1.
- Fmap handshake at edge e: lane k shows the value with o_left_en[k]=1 during the cycle after edge e+k, i.e. 1+k cycles of latency.
- Last-vector handshake at edge e: lane NUMBER_PE-1 shows it after edge e+NUMBER_PE-1 for one cycle. FSM enters IDLE and o_weight_en falls at edge e+NUMBER_PE+1. The new o_w_ready=1 appears in the same cycle.
- Back-to-back: a new weight set can be accepted in the first IDLE cycle. The skew line is empty by then.
- Reset mid-run clears everything asynchronously. No partial vector is emitted afterwards.

## Test plan
- Reset: assert i_rest during STREAM -> all outputs 0, o_w_ready=1 within the same cycle, and no enable pulses after release.
- Weight load: i_w_data lane0=32'hBDAC8916, lane8=32'hBDED8EF1 -> o_weight matches the next cycle, o_weight_en=1, o_busy=1, and o_x_ready=1.
- Single vector with last=1, lane0=32'hBD01D614, lane8=32'hBDAE231D, accepted at edge e -> o_left_en[k] is a one-cycle pulse after edge e+k with matching o_fmap lane. IDLE at e+10.
- Continuous run of 3 vectors (last on the third) -> o_left_en[k] high for exactly 3 consecutive cycles starting after e+k, forming a staircase across lanes 0..8. o_right_en==o_left_en throughout.
- Bubble: i_x_valid low for one cycle between two vectors -> each lane shows a one-cycle 0 in o_left_en and o_fmap=0, shifted by k.
- Contention: i_w_valid and i_x_valid both high in IDLE -> only the weight is accepted. During STREAM/DRAIN, i_w_valid high -> o_w_ready stays 0 and o_weight is unchanged.

Source files
------------

// File: rtl/mpe_feeder_if.sv
// Upstream handshake bundle for mpe_feeder: one weight-set channel and one fmap-vector channel.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface mpe_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUMBER_PE  = 9
);
    logic                            i_w_valid;
    logic                            o_w_ready;
    logic [NUMBER_PE*DATA_WIDTH-1:0] i_w_data;
    logic                            i_x_valid;
    logic                            o_x_ready;
    logic [NUMBER_PE*DATA_WIDTH-1:0] i_x_data;
    logic                            i_x_last;

    modport master (
        output i_w_valid, i_w_data, i_x_valid, i_x_data, i_x_last,
        input  o_w_ready, o_x_ready
    );

    modport slave (
        input  i_w_valid, i_w_data, i_x_valid, i_x_data, i_x_last,
        output o_w_ready, o_x_ready
    );
endinterface

// File: rtl/mpe_feeder.sv
// Feeder for the 9x1 MPE column: latches one weight set, then skews each fmap vector so lane k
// reaches PE k exactly k cycles after lane 0, with matching left/right enables.
module mpe_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUMBER_PE  = 9
) (
    input  logic                            i_clk,
    input  logic                            i_rest,
    mpe_feeder_if.slave                     s_if,
    output logic                            o_weight_en,
    output logic [NUMBER_PE*DATA_WIDTH-1:0] o_weight,
    output logic [NUMBER_PE*DATA_WIDTH-1:0] o_fmap,
    output logic [NUMBER_PE-1:0]            o_left_en,
    output logic [NUMBER_PE-1:0]            o_right_en,
    output logic                            o_busy,
    output logic [1:0]                      o_state
);
    localparam int CW = $clog2(NUMBER_PE + 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_w_ready;
    logic            w_x_ready;
    logic            w_w_fire;
    logic            w_x_fire;

    assign w_w_fire = s_if.i_w_valid & w_w_ready;
    assign w_x_fire = s_if.i_x_valid & w_x_ready;

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            o_weight <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_w_fire) begin
                o_weight <= s_if.i_w_data;
            end
        end
    end

    // The drain count covers the deepest lane plus one cycle, so the skew line is empty on entry to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_w_ready   = 1'b0;
        w_x_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_w_ready = 1'b1;
                if (s_if.i_w_valid) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_x_ready = 1'b1;
                if (s_if.i_x_valid && s_if.i_x_last) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = CW'(NUMBER_PE + 1);
                end
            end
            ST_DRAIN: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign s_if.o_w_ready = w_w_ready;
    assign s_if.o_x_ready = w_x_ready;
    assign o_weight_en    = (r_state != ST_IDLE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_state        = r_state;
    assign o_right_en     = o_left_en;

    for (genvar k = 0; k < NUMBER_PE; k++) begin : g_lane
        logic [k:0]            r_v;
        logic [DATA_WIDTH-1:0] r_d [k+1];

        // Bubbles carry zero data so idle slots present 0 on o_fmap.
        always_ff @(posedge i_clk or posedge i_rest) begin
            if (i_rest) begin
                r_v <= '0;
                for (int s = 0; s <= k; s++) begin
                    r_d[s] <= '0;
                end
            end else begin
                r_v[0] <= w_x_fire;
                r_d[0] <= w_x_fire ? s_if.i_x_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int s = 1; s <= k; s++) begin
                    r_v[s] <= r_v[s-1];
                    r_d[s] <= r_d[s-1];
                end
            end
        end

        assign o_fmap[k*DATA_WIDTH +: DATA_WIDTH] = r_d[k];
        assign o_left_en[k]                       = r_v[k];
    end
endmodule

// File: tb/tb_mpe_feeder.sv
// Directed bench for mpe_feeder: weight load, single/continuous/bubbled runs, contention and mid-run reset.
// Expected skew outputs come from an injected-slot table shifted by lane index.
module tb_mpe_feeder;
    localparam int DW = 32;
    localparam int NP = 9;
    localparam int VW = DW * NP;

    logic          clk;
    logic          rst;
    logic          o_weight_en;
    logic [VW-1:0] o_weight;
    logic [VW-1:0] o_fmap;
    logic [NP-1:0] o_left_en;
    logic [NP-1:0] o_right_en;
    logic          o_busy;
    logic [1:0]    o_state;

    int n_total;
    int n_bad;

    logic [VW-1:0] exp_w;
    logic          seq_v [16];
    logic [VW-1:0] seq_d [16];

    mpe_feeder_if #(.DATA_WIDTH(DW), .NUMBER_PE(NP)) u_if ();

    mpe_feeder #(.DATA_WIDTH(DW), .NUMBER_PE(NP)) u_dut (
        .i_clk       (clk),
        .i_rest      (rst),
        .s_if        (u_if),
        .o_weight_en (o_weight_en),
        .o_weight    (o_weight),
        .o_fmap      (o_fmap),
        .o_left_en   (o_left_en),
        .o_right_en  (o_right_en),
        .o_busy      (o_busy),
        .o_state     (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] mk_vec(input logic [31:0] l0, input logic [31:0] l8,
                                             input logic [31:0] base);
        logic [VW-1:0] v;
        v = '0;
        v[0 +: DW] = l0;
        for (int k = 1; k < NP - 1; k++) begin
            v[k*DW +: DW] = base + 32'(k);
        end
        v[(NP-1)*DW +: DW] = l8;
        return v;
    endfunction

    task automatic idle_inputs();
        u_if.i_w_valid = 1'b0;
        u_if.i_w_data  = '0;
        u_if.i_x_valid = 1'b0;
        u_if.i_x_data  = '0;
        u_if.i_x_last  = 1'b0;
    endtask

    // Offer a weight set in IDLE, optionally with a competing fmap vector.
    task automatic load_w(input logic [VW-1:0] w, input logic contend);
        u_if.i_w_valid = 1'b1;
        u_if.i_w_data  = w;
        u_if.i_x_valid = contend;
        u_if.i_x_data  = {NP{32'hCAFEF00D}};
        u_if.i_x_last  = contend;
        tick();
        idle_inputs();
        exp_w = w;
        check("w_load_weight", o_weight, w);
        check("w_load_weight_en", o_weight_en, 1'b1);
        check("w_load_busy", o_busy, 1'b1);
        check("w_load_x_ready", u_if.o_x_ready, 1'b1);
        check("w_load_w_ready", u_if.o_w_ready, 1'b0);
        check("w_load_no_fmap_en", o_left_en, '0);
        #1;
        tick();
        check("w_load_no_fmap_en2", o_left_en, '0);
        check("w_load_still_stream", u_if.o_x_ready, 1'b1);
    endtask

    // Drive n slots from seq_v/seq_d (last on final valid slot), then let it drain to IDLE.
    task automatic run_seq(input int n);
        int            last_i;
        int            idx;
        logic [NP-1:0] exp_en;
        logic [VW-1:0] exp_f;
        logic [VW-1:0] tmp;
        logic          exp_busy;
        last_i = 0;
        for (int i = 0; i < n; i++) begin
            if (seq_v[i]) last_i = i;
        end
        for (int c = 0; c <= last_i + NP + 1; c++) begin
            if (c < n) begin
                u_if.i_x_valid = seq_v[c];
                u_if.i_x_data  = seq_v[c] ? seq_d[c] : {NP{32'hDEADBEEF}};
                u_if.i_x_last  = (c == last_i);
            end else begin
                u_if.i_x_valid = 1'b0;
                u_if.i_x_data  = {NP{32'h55AA55AA}};
                u_if.i_x_last  = 1'b1;
            end
            u_if.i_w_valid = (c < last_i + NP);
            u_if.i_w_data  = {NP{32'h12345678}};
            tick();
            exp_en = '0;
            exp_f  = '0;
            for (int k = 0; k < NP; k++) begin
                idx = c - k;
                if (idx >= 0 && idx < n && seq_v[idx]) begin
                    exp_en[k] = 1'b1;
                    tmp = seq_d[idx];
                    exp_f[k*DW +: DW] = tmp[k*DW +: DW];
                end
            end
            exp_busy = (c < last_i + NP + 1);
            check($sformatf("left_en_c%0d", c), o_left_en, exp_en);
            check($sformatf("right_en_c%0d", c), o_right_en, exp_en);
            check($sformatf("fmap_c%0d", c), o_fmap, exp_f);
            check($sformatf("busy_c%0d", c), o_busy, exp_busy);
            check($sformatf("weight_en_c%0d", c), o_weight_en, exp_busy);
            check($sformatf("w_ready_c%0d", c), u_if.o_w_ready, !exp_busy);
            check($sformatf("weight_hold_c%0d", c), o_weight, exp_w);
        end
        idle_inputs();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_w   = '0;
        idle_inputs();
        rst = 1'b1;
        #2;
        check("rst_w_ready", u_if.o_w_ready, 1'b1);
        check("rst_x_ready", u_if.o_x_ready, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_weight_en", o_weight_en, 1'b0);
        check("rst_weight", o_weight, '0);
        check("rst_fmap", o_fmap, '0);
        check("rst_left_en", o_left_en, '0);
        tick();
        rst = 1'b0;
        tick();

        // Weight load with a competing fmap offer in IDLE, then a single-vector run.
        load_w(mk_vec(32'hBDAC8916, 32'hBDED8EF1, 32'h3F000000), 1'b1);
        seq_v[0] = 1'b1;
        seq_d[0] = mk_vec(32'hBD01D614, 32'hBDAE231D, 32'h40000000);
        run_seq(1);

        // Back-to-back weight load in the first IDLE cycle, then three continuous vectors.
        load_w(mk_vec(32'h11111111, 32'h99999999, 32'h21000000), 1'b0);
        for (int i = 0; i < 3; i++) begin
            seq_v[i] = 1'b1;
            seq_d[i] = mk_vec(32'hA0000000 + 32'(i), 32'hA8000000 + 32'(i), 32'h30000000 + 32'(i << 8));
        end
        run_seq(3);

        // Vector, bubble, vector.
        load_w(mk_vec(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h50000000), 1'b0);
        seq_v[0] = 1'b1;
        seq_d[0] = mk_vec(32'hC0000001, 32'hC8000001, 32'h60000000);
        seq_v[1] = 1'b0;
        seq_d[1] = '0;
        seq_v[2] = 1'b1;
        seq_d[2] = mk_vec(32'hC0000002, 32'hC8000002, 32'h70000000);
        run_seq(3);

        // Reset in the middle of a run; nothing may emerge afterwards.
        load_w(mk_vec(32'h77777777, 32'h88888888, 32'h7F000000), 1'b0);
        u_if.i_x_valid = 1'b1;
        u_if.i_x_data  = mk_vec(32'hE0000000, 32'hE8000000, 32'h01000000);
        u_if.i_x_last  = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_w_ready", u_if.o_w_ready, 1'b1);
        check("mid_rst_x_ready", u_if.o_x_ready, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_weight_en", o_weight_en, 1'b0);
        check("mid_rst_weight", o_weight, '0);
        check("mid_rst_fmap", o_fmap, '0);
        check("mid_rst_left_en", o_left_en, '0);
        check("mid_rst_right_en", o_right_en, '0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < NP + 3; c++) begin
            tick();
            check($sformatf("post_rst_left_en_c%0d", c), o_left_en, '0);
            check($sformatf("post_rst_fmap_c%0d", c), o_fmap, '0);
            check($sformatf("post_rst_busy_c%0d", c), o_busy, 1'b0);
            check($sformatf("post_rst_x_ready_c%0d", c), u_if.o_x_ready, 1'b0);
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
